// File: rtl/pl2ps_axis_arbiter.sv
// Packet-level round-robin arbiter merging NUM_SRC AXI-Stream sources onto the PL->PS S2MM stream.
// Optional macro PL2PS_ARB_PKT_LIMIT_EN enables per-packet beat limiting with truncation/drain.
module pl2ps_axis_arbiter #(
   parameter int NUM_SRC      = 4,
   parameter int DATA_W       = 32,
   parameter int MAX_PKT_BEAT = 4096
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic [NUM_SRC-1:0]            cfg_src_en,
   input  logic [NUM_SRC*DATA_W-1:0]     s_axis_tdata,
   input  logic [NUM_SRC*DATA_W/8-1:0]   s_axis_tkeep,
   input  logic [NUM_SRC-1:0]            s_axis_tlast,
   input  logic [NUM_SRC-1:0]            s_axis_tvalid,
   output logic [NUM_SRC-1:0]            s_axis_tready,
   output logic [DATA_W-1:0]             m_axis_tdata,
   output logic [DATA_W/8-1:0]           m_axis_tkeep,
   output logic                          m_axis_tlast,
   output logic                          m_axis_tvalid,
   input  logic                          m_axis_tready,
   output logic                          stat_busy,
   output logic [$clog2(NUM_SRC)-1:0]    stat_grant,
   output logic                          stat_trunc
);

   localparam int GW = $clog2(NUM_SRC);
   localparam int KW = DATA_W/8;

   if (NUM_SRC < 2 || NUM_SRC > 8 || MAX_PKT_BEAT < 1) begin : g_param_check
      $error("pl2ps_axis_arbiter: unsupported NUM_SRC or MAX_PKT_BEAT");
   end

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_XFER
`ifdef PL2PS_ARB_PKT_LIMIT_EN
      , ST_DRAIN
`endif
   } state_t;

   state_t              state_q, state_d;
   logic [GW-1:0]       grant_q, grant_d;
   logic [GW-1:0]       last_grant_q, last_grant_d;
   logic [NUM_SRC-1:0]  req;
   logic                arb_found;
   logic [GW-1:0]       arb_idx;
   int unsigned         cand;

   logic                src_valid, src_last, src_rdy, fwd_rdy, accept, trunc_hit;
   logic [DATA_W-1:0]   src_data;
   logic [KW-1:0]       src_keep;
   logic [NUM_SRC-1:0]  tready_c;

   logic [DATA_W-1:0]   out_data_q;
   logic [KW-1:0]       out_keep_q;
   logic                out_last_q, out_valid_q, trunc_q;

   assign req = s_axis_tvalid & cfg_src_en;

   // Rotating priority search starting just after the last completed grant.
   always_comb begin
      arb_found = 1'b0;
      arb_idx   = '0;
      cand      = 0;
      for (int unsigned k = 1; k <= NUM_SRC; k++) begin
         cand = (32'(last_grant_q) + k) % NUM_SRC;
         if (!arb_found && req[GW'(cand)]) begin
            arb_found = 1'b1;
            arb_idx   = GW'(cand);
         end
      end
   end

   always_comb begin
      src_valid = s_axis_tvalid[grant_q];
      src_last  = s_axis_tlast[grant_q];
      src_data  = s_axis_tdata[grant_q*DATA_W +: DATA_W];
      src_keep  = s_axis_tkeep[grant_q*KW +: KW];
      fwd_rdy   = ~out_valid_q | m_axis_tready;
   end

   always_comb begin
      tready_c = '0;
      src_rdy  = 1'b0;
      case (state_q)
         ST_XFER:  src_rdy = fwd_rdy;
`ifdef PL2PS_ARB_PKT_LIMIT_EN
         ST_DRAIN: src_rdy = 1'b1;
`endif
         default:  src_rdy = 1'b0;
      endcase
      tready_c[grant_q] = src_rdy;
      accept = src_valid & src_rdy;
   end

   assign s_axis_tready = tready_c;

`ifdef PL2PS_ARB_PKT_LIMIT_EN
   localparam int CNT_W = $clog2(MAX_PKT_BEAT + 1);
   logic [CNT_W-1:0] beat_cnt_q;

   // Beat MAX_PKT_BEAT carrying no source tlast is the forced end of packet.
   assign trunc_hit = (state_q == ST_XFER) & accept & ~src_last &
                      (beat_cnt_q == CNT_W'(MAX_PKT_BEAT - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         beat_cnt_q <= '0;
      end else if (state_q == ST_IDLE) begin
         beat_cnt_q <= '0;
      end else if (state_q == ST_XFER && accept) begin
         beat_cnt_q <= beat_cnt_q + 1'b1;
      end
   end
`else
   assign trunc_hit = 1'b0;
`endif

   always_comb begin
      state_d      = state_q;
      grant_d      = grant_q;
      last_grant_d = last_grant_q;
      case (state_q)
         ST_IDLE: begin
            if (arb_found) begin
               grant_d = arb_idx;
               state_d = ST_XFER;
            end
         end
         ST_XFER: begin
            if (accept && src_last) begin
               last_grant_d = grant_q;
               state_d      = ST_IDLE;
            end
`ifdef PL2PS_ARB_PKT_LIMIT_EN
            else if (trunc_hit) begin
               state_d = ST_DRAIN;
            end
`endif
         end
`ifdef PL2PS_ARB_PKT_LIMIT_EN
         ST_DRAIN: begin
            if (accept && src_last) begin
               last_grant_d = grant_q;
               state_d      = ST_IDLE;
            end
         end
`endif
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ST_IDLE;
         grant_q      <= '0;
         last_grant_q <= GW'(NUM_SRC - 1);
         trunc_q      <= 1'b0;
      end else begin
         state_q      <= state_d;
         grant_q      <= grant_d;
         last_grant_q <= last_grant_d;
         trunc_q      <= trunc_hit;
      end
   end

   // Output stage: drained beats discarded in DRAIN never reach this register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_data_q  <= '0;
         out_keep_q  <= '0;
         out_last_q  <= 1'b0;
         out_valid_q <= 1'b0;
      end else if (state_q == ST_XFER && accept) begin
         out_data_q  <= src_data;
         out_keep_q  <= src_keep;
         out_last_q  <= src_last | trunc_hit;
         out_valid_q <= 1'b1;
      end else if (m_axis_tready) begin
         out_valid_q <= 1'b0;
      end
   end

   assign m_axis_tdata  = out_data_q;
   assign m_axis_tkeep  = out_keep_q;
   assign m_axis_tlast  = out_last_q;
   assign m_axis_tvalid = out_valid_q;
   assign stat_busy     = (state_q != ST_IDLE);
   assign stat_grant    = grant_q;
   assign stat_trunc    = trunc_q;

endmodule

// File: tb/tb_pl2ps_axis_arbiter.sv
// Self-checking bench for pl2ps_axis_arbiter: queued source packets, expected output stream
// built in round-robin order; truncation expectations follow PL2PS_ARB_PKT_LIMIT_EN.
module tb_pl2ps_axis_arbiter;

   localparam int NS   = 4;
   localparam int DW   = 32;
   localparam int KW   = DW/8;
   localparam int MAXB = 16;
`ifdef PL2PS_ARB_PKT_LIMIT_EN
   localparam int EXP_TRUNC = 1;
`else
   localparam int EXP_TRUNC = 0;
`endif

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic [NS-1:0]     cfg_src_en;
   logic [NS*DW-1:0]  s_axis_tdata;
   logic [NS*KW-1:0]  s_axis_tkeep;
   logic [NS-1:0]     s_axis_tlast;
   logic [NS-1:0]     s_axis_tvalid;
   logic [NS-1:0]     s_axis_tready;
   logic [DW-1:0]     m_axis_tdata;
   logic [KW-1:0]     m_axis_tkeep;
   logic              m_axis_tlast;
   logic              m_axis_tvalid;
   logic              m_axis_tready;
   logic              stat_busy;
   logic [1:0]        stat_grant;
   logic              stat_trunc;

   pl2ps_axis_arbiter #(.NUM_SRC(NS), .DATA_W(DW), .MAX_PKT_BEAT(MAXB)) dut (
      .clk(clk), .rst_n(rst_n), .cfg_src_en(cfg_src_en),
      .s_axis_tdata(s_axis_tdata), .s_axis_tkeep(s_axis_tkeep), .s_axis_tlast(s_axis_tlast),
      .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
      .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep), .m_axis_tlast(m_axis_tlast),
      .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
      .stat_busy(stat_busy), .stat_grant(stat_grant), .stat_trunc(stat_trunc)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [DW-1:0] data;
      logic [KW-1:0] keep;
      logic          last;
      int            src;
   } beat_t;

   beat_t src_q [NS][$];
   beat_t exp_q [$];

   int          errors = 0;
   int          checks = 0;
   int          cyc = 0;
   int          prev_last = -1;
   int          trunc_cnt = 0;
   int          rdy_mode = 0;
   int          s_acc [NS];
   bit          mid [NS];
   bit          mon_en = 1'b1;
   bit          gap_en = 1'b0;
   bit          grant_chk = 1'b0;
   bit          thru_chk = 1'b0;
   bit          out_first = 1'b1;
   bit          hold_pending = 1'b0;
   bit          rdy_tog = 1'b0;
   logic [37:0] hold_val;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic add_pkt(input int src, input int len, input bit exp_en);
      beat_t b;
      for (int k = 0; k < len; k++) begin
         b.data = $urandom;
         b.keep = KW'($urandom);
         b.last = (k == len - 1);
         b.src  = src;
         src_q[src].push_back(b);
         if (exp_en) begin
`ifdef PL2PS_ARB_PKT_LIMIT_EN
            if (k < MAXB) begin
               if (k == MAXB - 1) b.last = 1'b1;
               exp_q.push_back(b);
            end
`else
            exp_q.push_back(b);
`endif
         end
      end
   endtask

   task automatic drive();
      for (int i = 0; i < NS; i++) begin
         if (src_q[i].size() > 0 && !(gap_en && mid[i] && $urandom_range(3) == 0)) begin
            s_axis_tvalid[i]         = 1'b1;
            s_axis_tdata[i*DW +: DW] = src_q[i][0].data;
            s_axis_tkeep[i*KW +: KW] = src_q[i][0].keep;
            s_axis_tlast[i]          = src_q[i][0].last;
         end else begin
            s_axis_tvalid[i]         = 1'b0;
            s_axis_tdata[i*DW +: DW] = $urandom;
            s_axis_tkeep[i*KW +: KW] = KW'($urandom);
            s_axis_tlast[i]          = 1'($urandom);
         end
      end
      case (rdy_mode)
         0:       m_axis_tready = 1'b1;
         1:       m_axis_tready = 1'($urandom_range(1));
         default: begin rdy_tog = ~rdy_tog; m_axis_tready = rdy_tog; end
      endcase
   endtask

   task automatic tick();
      logic          m_fire;
      logic [NS-1:0] s_fire;
      logic [37:0]   cur;
      beat_t         e;
      @(negedge clk);
      m_fire = m_axis_tvalid & m_axis_tready;
      s_fire = s_axis_tvalid & s_axis_tready;
      if (stat_trunc) trunc_cnt++;
      cur = {m_axis_tvalid, m_axis_tlast, m_axis_tkeep, m_axis_tdata};
      if (mon_en) begin
         if (hold_pending) check("stall_hold", 64'(cur), 64'(hold_val));
         hold_pending = m_axis_tvalid & ~m_axis_tready;
         hold_val     = cur;
         if (m_fire) begin
            check("beat_expected", 64'(exp_q.size() > 0), 64'(1));
            if (exp_q.size() > 0) begin
               e = exp_q.pop_front();
               check("out_data", 64'(m_axis_tdata), 64'(e.data));
               check("out_keep", 64'(m_axis_tkeep), 64'(e.keep));
               check("out_last", 64'(m_axis_tlast), 64'(e.last));
               if (grant_chk && out_first) begin
                  check("grant_src", 64'(stat_grant), 64'(e.src));
                  if (!e.last) check("busy_in_pkt", 64'(stat_busy), 64'(1));
               end
               if (thru_chk && e.last) begin
                  if (prev_last >= 0) check("pkt_period", 64'(cyc - prev_last), 64'(5));
                  prev_last = cyc;
               end
               out_first = e.last;
            end
         end
      end
      @(posedge clk);
      #1;
      cyc++;
      for (int i = 0; i < NS; i++) begin
         if (s_fire[i] && src_q[i].size() > 0) begin
            e = src_q[i].pop_front();
            mid[i] = !e.last;
            s_acc[i]++;
         end
      end
      drive();
   endtask

   task automatic run(input int max_cyc);
      int n = 0;
      while (exp_q.size() > 0 && n < max_cyc) begin
         tick();
         n++;
      end
      check("drain_timeout", 64'(exp_q.size()), 64'(0));
      repeat (3) tick();
      check("idle_busy", 64'(stat_busy), 64'(0));
      check("idle_valid", 64'(m_axis_tvalid), 64'(0));
   endtask

   initial begin
      int n;
      cfg_src_en = '1;
      for (int i = 0; i < NS; i++) begin s_acc[i] = 0; mid[i] = 1'b0; end

      // Reset with every source valid; afterwards source 0 must win first.
      for (int s = 0; s < NS; s++) add_pkt(s, 4, 1'b1);
      drive();
      grant_chk = 1'b1;
      repeat (3) tick();
      check("rst_tready", 64'(s_axis_tready), 64'(0));
      check("rst_mvalid", 64'(m_axis_tvalid), 64'(0));
      check("rst_busy",   64'(stat_busy), 64'(0));
      check("rst_grant",  64'(stat_grant), 64'(0));
      check("rst_trunc",  64'(stat_trunc), 64'(0));
      check("rst_mdata",  64'(m_axis_tdata), 64'(0));
      rst_n = 1'b1;
      run(200);

      // Fairness with full throughput: 4-beat packets every 5 cycles in 0,1,2,3 order.
      thru_chk = 1'b1;
      prev_last = -1;
      for (int r = 0; r < 3; r++)
         for (int s = 0; s < NS; s++) add_pkt(s, 4, 1'b1);
      drive();
      run(400);
      thru_chk  = 1'b0;
      grant_chk = 1'b0;

      // Fairness under random backpressure, mid-packet valid gaps and random lengths.
      gap_en   = 1'b1;
      rdy_mode = 1;
      for (int r = 0; r < 3; r++)
         for (int s = 0; s < NS; s++) add_pkt(s, $urandom_range(6, 1), 1'b1);
      drive();
      run(2000);

      // Source 2 disabled: never granted while its packets wait.
      cfg_src_en = 4'b1011;
      for (int r = 0; r < 2; r++)
         for (int s = 0; s < NS; s++) add_pkt(s, 3, s != 2);
      drive();
      run(1000);
      check("src2_never", 64'(src_q[2].size()), 64'(6));
      src_q[2].delete();
      mid[2] = 1'b0;

      // Clearing enable mid-packet lets the packet complete.
      cfg_src_en = 4'b1111;
      gap_en = 1'b0;
      add_pkt(0, 5, 1'b1);
      add_pkt(1, 3, 1'b1);
      for (int i = 0; i < NS; i++) s_acc[i] = 0;
      drive();
      n = 0;
      while (s_acc[0] == 0 && n < 50) begin tick(); n++; end
      check("en_start", 64'(s_acc[0] >= 1), 64'(1));
      cfg_src_en[0] = 1'b0;
      run(500);
      check("en_src0_done", 64'(src_q[0].size()), 64'(0));
      cfg_src_en = 4'b1111;

      // Reset in the middle of a 6-beat packet.
      rdy_mode = 0;
      mon_en   = 1'b0;
      add_pkt(0, 6, 1'b0);
      for (int i = 0; i < NS; i++) s_acc[i] = 0;
      drive();
      n = 0;
      while (s_acc[0] < 3 && n < 50) begin tick(); n++; end
      check("rst_mid_reach", 64'(s_acc[0] >= 3), 64'(1));
      rst_n = 1'b0;
      tick();
      check("rstmid_mvalid", 64'(m_axis_tvalid), 64'(0));
      check("rstmid_tready", 64'(s_axis_tready), 64'(0));
      check("rstmid_busy",   64'(stat_busy), 64'(0));
      check("rstmid_mdata",  64'(m_axis_tdata), 64'(0));
      src_q[0].delete();
      for (int i = 0; i < NS; i++) mid[i] = 1'b0;
      repeat (2) tick();
      rst_n        = 1'b1;
      mon_en       = 1'b1;
      hold_pending = 1'b0;
      out_first    = 1'b1;
      grant_chk    = 1'b1;
      add_pkt(0, 3, 1'b1);
      add_pkt(3, 3, 1'b1);
      drive();
      run(200);
      grant_chk = 1'b0;

      // Over-long packet, then a normal one; then exactly MAXB beats.
      trunc_cnt = 0;
      add_pkt(1, 20, 1'b1);
      add_pkt(2, 5, 1'b1);
      drive();
      run(300);
      check("trunc_pulses",  64'(trunc_cnt), 64'(EXP_TRUNC));
      check("src1_absorbed", 64'(src_q[1].size()), 64'(0));
      trunc_cnt = 0;
      add_pkt(1, MAXB, 1'b1);
      drive();
      run(200);
      check("trunc_exact", 64'(trunc_cnt), 64'(0));

      // Alternating ready on an 8-beat packet from source 2.
      rdy_mode = 2;
      add_pkt(2, 8, 1'b1);
      drive();
      run(200);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
